// File: rtl/multchan_deframer_if.sv
// Symbol input and message output bundle of the link deframer.
// master is the deframer side; slave is the link receiver / message consumer side.
interface multchan_deframer_if #(
  parameter int PACKET_SIZE = 8,
  parameter int MESSAGE_BIT = 184,
  parameter int CHANNEL_BIT = 1
);
  logic                   in_valid;
  logic [PACKET_SIZE-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CHANNEL_BIT-1:0] out_channel;
  logic [4:0]             out_length;
  logic [MESSAGE_BIT-1:0] out_data;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_channel, out_length, out_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_channel, out_length, out_data
  );
endinterface

// File: rtl/multchan_deframer.sv
// Receive-side deframer: parses HEAD/CHAN/LEN/DATA/TAIL symbols into messages,
// holds one completed message on a valid/ready port and counts framing errors and drops.
module multchan_deframer #(
  parameter int PACKET_SIZE = 8,
  parameter int MESSAGE_BIT = 184,
  parameter int CHANNEL_BIT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  multchan_deframer_if.master link,
  output logic [7:0]          err_count,
  output logic [7:0]          drop_count
);

  localparam int         TYPE_MSB = PACKET_SIZE - 1;
  localparam logic [4:0] MAX_LEN  = 5'(MESSAGE_BIT / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAN,
    S_LEN,
    S_DATA,
    S_TAIL
  } state_t;

  state_t                 state_reg;
  logic [4:0]             id_reg;
  logic [4:0]             len_reg;
  logic [CHANNEL_BIT-1:0] chan_reg;
  logic [7:0]             idx_reg;
  logic [MESSAGE_BIT-1:0] asm_reg;

  logic [2:0]             sym_kind;
  logic [4:0]             sym_field;
  logic                   is_head, is_chan, is_len, is_tail, is_data;
  logic [7:0]             idx_next;
  logic                   data_last;
  logic [MESSAGE_BIT-1:0] asm_next;
  logic [MESSAGE_BIT-1:0] len_mask;
  logic                   msg_done;
  logic                   frame_err;

  always_comb begin
    sym_kind  = link.in_data[TYPE_MSB -: 3];
    sym_field = link.in_data[4:0];
    is_head   = (sym_kind == 3'b100);
    is_chan   = (sym_kind == 3'b101);
    is_len    = (sym_kind == 3'b110);
    is_tail   = (sym_kind == 3'b111);
    is_data   = !link.in_data[TYPE_MSB];
  end

  // Bits shifted past MESSAGE_BIT fall off the top of the assembly register.
  assign idx_next  = idx_reg + 8'd7;
  assign data_last = (idx_next >= {len_reg, 3'b000});
  assign asm_next  = asm_reg | (MESSAGE_BIT'(link.in_data[6:0]) << idx_reg);

  genvar gi;
  generate
    for (gi = 0; gi < MESSAGE_BIT; gi++) begin : g_mask
      assign len_mask[gi] = (32'(gi) < {24'd0, len_reg, 3'b000});
    end
  endgenerate

  assign msg_done = link.in_valid && (state_reg == S_TAIL) && is_tail && (sym_field == id_reg);

  always_comb begin
    frame_err = 1'b0;
    if (link.in_valid) begin
      if (is_head) begin
        frame_err = (state_reg != S_IDLE);
      end else begin
        case (state_reg)
          S_CHAN:  frame_err = !is_chan;
          S_LEN:   frame_err = !is_len || (sym_field > MAX_LEN);
          S_DATA:  frame_err = !is_data;
          S_TAIL:  frame_err = !msg_done;
          default: frame_err = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg        <= S_IDLE;
      id_reg           <= '0;
      len_reg          <= '0;
      chan_reg         <= '0;
      idx_reg          <= '0;
      asm_reg          <= '0;
      link.out_valid   <= 1'b0;
      link.out_channel <= '0;
      link.out_length  <= '0;
      link.out_data    <= '0;
      err_count        <= '0;
      drop_count       <= '0;
    end else begin
      if (link.out_valid && link.out_ready) begin
        link.out_valid <= 1'b0;
      end

      // A completion in the transfer cycle refills the holding register directly.
      if (msg_done) begin
        if (!link.out_valid || link.out_ready) begin
          link.out_valid   <= 1'b1;
          link.out_channel <= chan_reg;
          link.out_length  <= len_reg;
          link.out_data    <= asm_reg & len_mask;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      if (frame_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (link.in_valid) begin
        if (is_head) begin
          id_reg    <= sym_field;
          asm_reg   <= '0;
          idx_reg   <= '0;
          state_reg <= S_CHAN;
        end else begin
          case (state_reg)
            S_CHAN: begin
              if (is_chan) begin
                chan_reg  <= link.in_data[CHANNEL_BIT-1:0];
                state_reg <= S_LEN;
              end else begin
                state_reg <= S_IDLE;
              end
            end
            S_LEN: begin
              if (is_len && (sym_field <= MAX_LEN)) begin
                len_reg   <= sym_field;
                state_reg <= S_DATA;
              end else begin
                state_reg <= S_IDLE;
              end
            end
            S_DATA: begin
              if (is_data) begin
                asm_reg <= asm_next;
                idx_reg <= idx_next;
                if (data_last) begin
                  state_reg <= S_TAIL;
                end
              end else begin
                state_reg <= S_IDLE;
              end
            end
            default: state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
